// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment Wishbone slave: register map,
// CTRL field layout and the bus handshake state encoding.
package seg7_pkg;

  localparam logic [1:0] SEG7_DATA = 2'd0;
  localparam logic [1:0] SEG7_CTRL = 2'd1;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_DP_LSB    = 4;
  localparam int CTRL_BLANK_LSB = 8;

  typedef struct packed {
    logic [3:0] blank;
    logic [3:0] dp;
    logic       en;
  } seg7_ctrl_t;

  localparam seg7_ctrl_t CTRL_RESET = '{blank: 4'h0, dp: 4'h0, en: 1'b1};

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  function automatic logic [31:0] ctrl_to_word(input seg7_ctrl_t c);
    logic [31:0] w;
    w                        = '0;
    w[CTRL_EN_BIT]           = c.en;
    w[CTRL_DP_LSB +: 4]      = c.dp;
    w[CTRL_BLANK_LSB +: 4]   = c.blank;
    return w;
  endfunction

endpackage

// File: rtl/seg7_wb_if.sv
// Wishbone classic bus bundle as seen from a slave; only the signals a
// simple register slave needs.
interface wishboneSlave;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic        we_i;
  logic        stb_i;
  logic        cyc_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport slave (
    input  adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    output dat_o, ack_o
  );

  modport master (
    output adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    input  dat_o, ack_o
  );
endinterface

// File: rtl/seg7_decode.sv
// Hex nibble to active-low seven-segment pattern, bit0 = segment a.
module seg7_decode (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = 7'h7F;
    case (nibble_i)
      4'h0: seg_n_o = 7'h40;
      4'h1: seg_n_o = 7'h79;
      4'h2: seg_n_o = 7'h24;
      4'h3: seg_n_o = 7'h30;
      4'h4: seg_n_o = 7'h19;
      4'h5: seg_n_o = 7'h12;
      4'h6: seg_n_o = 7'h02;
      4'h7: seg_n_o = 7'h78;
      4'h8: seg_n_o = 7'h00;
      4'h9: seg_n_o = 7'h10;
      4'hA: seg_n_o = 7'h08;
      4'hB: seg_n_o = 7'h03;
      4'hC: seg_n_o = 7'h46;
      4'hD: seg_n_o = 7'h21;
      4'hE: seg_n_o = 7'h06;
      4'hF: seg_n_o = 7'h0E;
      default: seg_n_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_wb_slave.sv
// Wishbone classic slave driving a four-digit multiplexed seven-segment
// display from a 16-bit hex value and a control register.
module seg7_wb_slave
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  wishboneSlave.slave bus,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n
);

  localparam int unsigned   PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  bus_state_e    state_q, state_d;
  logic          accept;
  logic          wr_en;
  logic [1:0]    adr;
  logic [31:0]   rdata;
  logic [31:0]   dat_q, dat_d;
  logic [15:0]   data_q, data_d;
  seg7_ctrl_t    ctrl_q, ctrl_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic          wrap;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_sel_n;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;
  logic          lit;
  logic          unused_bus;

  assign adr        = bus.adr_i[3:2];
  assign unused_bus = ^{bus.adr_i[31:4], bus.adr_i[1:0], bus.dat_i[31:16], bus.sel_i[3:2]};

  // ACK is a one-cycle pulse; holding stb yields an ack every other cycle
  always_comb begin
    state_d = BUS_IDLE;
    accept  = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (bus.cyc_i && bus.stb_i) begin
          state_d = BUS_ACK;
          accept  = 1'b1;
        end
      end
      BUS_ACK: state_d = BUS_IDLE;
      default: state_d = BUS_IDLE;
    endcase
  end

  assign wr_en = accept & bus.we_i;

  always_comb begin
    rdata = '0;
    case (adr)
      SEG7_DATA: rdata = {16'h0000, data_q};
      SEG7_CTRL: rdata = ctrl_to_word(ctrl_q);
      default:   rdata = '0;
    endcase
  end

  assign dat_d = accept ? rdata : '0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_data_lane
      assign data_d[gi*8 +: 8] = (wr_en && adr == SEG7_DATA && bus.sel_i[gi])
                                 ? bus.dat_i[gi*8 +: 8] : data_q[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_en && adr == SEG7_CTRL) begin
      if (bus.sel_i[0]) begin
        ctrl_d.en = bus.dat_i[CTRL_EN_BIT];
        ctrl_d.dp = bus.dat_i[CTRL_DP_LSB +: 4];
      end
      if (bus.sel_i[1]) begin
        ctrl_d.blank = bus.dat_i[CTRL_BLANK_LSB +: 4];
      end
    end
  end

  assign wrap    = (presc_q == PRESC_LAST);
  assign presc_d = wrap ? '0 : presc_q + 1'b1;
  assign digit_d = wrap ? digit_q + 2'd1 : digit_q;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_anode
      assign an_sel_n[gi] = (digit_q != 2'(gi));
    end
  endgenerate

  assign nibble = data_q[{digit_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble_i (nibble),
    .seg_n_o  (seg_dec)
  );

  // All three pin groups come from the same flops stage so anode and segments never skew
  assign lit  = ctrl_q.en & ~ctrl_q.blank[digit_q];
  assign an_d  = lit ? an_sel_n : 4'hF;
  assign seg_d = lit ? seg_dec : 7'h7F;
  assign dp_d  = lit ? ~ctrl_q.dp[digit_q] : 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BUS_IDLE;
      dat_q   <= '0;
      data_q  <= '0;
      ctrl_q  <= CTRL_RESET;
      presc_q <= '0;
      digit_q <= '0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.ack_o = (state_q == BUS_ACK);
  assign bus.dat_o = dat_q;
  assign an_n      = an_q;
  assign seg_n     = seg_q;
  assign dp_n      = dp_q;

endmodule

// File: tb/tb_seg7_wb_slave.sv
// Self-checking bench for seg7_wb_slave: vector table of bus accesses with a
// read-data scoreboard, a cycle model of the display, and hand-written corner cases.
module tb_seg7_wb_slave;

  localparam int SCAN_DIV = 4;
  localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;

  wishboneSlave wb ();

  seg7_wb_slave #(.SCAN_DIV(SCAN_DIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (wb),
    .seg_n (seg_n),
    .dp_n  (dp_n),
    .an_n  (an_n)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q [$];
  bit          mon_en = 1'b0;

  typedef struct {
    logic [1:0]  adr;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h required 0x%0h", name, $time, act, exp);
    end
  endtask

  // Display model: outputs follow the register/scan state present before each edge
  logic [15:0] m_data;
  logic        m_en;
  logic [3:0]  m_dp, m_blank;
  int          m_presc, m_digit;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_data = 16'h0; m_en = 1'b1; m_dp = 4'h0; m_blank = 4'h0;
      m_presc = 0; m_digit = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      if (m_en && !m_blank[m_digit]) begin
        e_an  = ~(4'b0001 << m_digit);
        e_seg = DEC[m_data[m_digit*4 +: 4]];
        e_dp  = ~m_dp[m_digit];
      end else begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end
      if (m_presc == SCAN_DIV - 1) begin
        m_presc = 0;
        m_digit = (m_digit + 1) % 4;
      end else begin
        m_presc = m_presc + 1;
      end
      if (wb.cyc_i && wb.stb_i && !wb.ack_o && wb.we_i) begin
        case (wb.adr_i[3:2])
          2'd0: begin
            if (wb.sel_i[0]) m_data[7:0]  = wb.dat_i[7:0];
            if (wb.sel_i[1]) m_data[15:8] = wb.dat_i[15:8];
          end
          2'd1: begin
            if (wb.sel_i[0]) begin m_en = wb.dat_i[0]; m_dp = wb.dat_i[7:4]; end
            if (wb.sel_i[1]) m_blank = wb.dat_i[11:8];
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      check("mon an_n",  32'(an_n),  32'(e_an));
      check("mon seg_n", 32'(seg_n), 32'(e_seg));
      check("mon dp_n",  32'(dp_n),  32'(e_dp));
    end
  end

  task automatic wb_xfer(input logic [1:0] adr, input bit we, input logic [3:0] sel,
                         input logic [31:0] dat, input logic [31:0] exp, input string name);
    int n;
    @(negedge clock);
    wb.adr_i = {28'h0, adr, 2'b00};
    wb.we_i  = we;
    wb.sel_i = sel;
    wb.dat_i = dat;
    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    if (!we) sb_q.push_back(exp);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!wb.ack_o && n < 8);
    check({name, " ack latency"}, 32'(n), 32'd1);
    if (!we && sb_q.size() > 0) check({name, " rdata"}, wb.dat_o, sb_q.pop_front());
    $display("xfer %s adr=%0d we=%0b sel=%h dat=%h dat_o=%h", name, adr, we, sel, dat, wb.dat_o);
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
    wb.we_i  = 1'b0;
    @(negedge clock);
    check({name, " ack drop"}, 32'(wb.ack_o), 32'd0);
    check({name, " dat_o idle"}, wb.dat_o, 32'd0);
  endtask

  task automatic wait_an(input logic [3:0] v, input string name);
    int n;
    n = 0;
    while (an_n !== v && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({name, " sync"}, 32'(an_n), 32'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] seq [4];
    int acks, cnt;
    seq = '{7'h19, 7'h30, 7'h24, 7'h79};

    vecs[0]  = '{2'd0, 1'b1, 4'hF, 32'h0000_1234, 32'h0};
    vecs[1]  = '{2'd0, 1'b0, 4'hF, 32'h0,         32'h0000_1234};
    vecs[2]  = '{2'd0, 1'b1, 4'h2, 32'h0000_AB00, 32'h0};
    vecs[3]  = '{2'd0, 1'b0, 4'hF, 32'h0,         32'h0000_AB34};
    vecs[4]  = '{2'd1, 1'b0, 4'hF, 32'h0,         32'h0000_0001};
    vecs[5]  = '{2'd1, 1'b1, 4'hF, 32'h0000_0211, 32'h0};
    vecs[6]  = '{2'd1, 1'b0, 4'hF, 32'h0,         32'h0000_0211};
    vecs[7]  = '{2'd3, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{2'd0, 1'b0, 4'hF, 32'h0,         32'h0000_AB34};
    vecs[9]  = '{2'd1, 1'b0, 4'hF, 32'h0,         32'h0000_0211};
    vecs[10] = '{2'd2, 1'b0, 4'hF, 32'h0,         32'h0};
    vecs[11] = '{2'd0, 1'b1, 4'hC, 32'hFFFF_5678, 32'h0};
    vecs[12] = '{2'd0, 1'b0, 4'hF, 32'h0,         32'h0000_AB34};
    vecs[13] = '{2'd1, 1'b1, 4'h1, 32'hFFFF_FFFF, 32'h0};
    vecs[14] = '{2'd1, 1'b0, 4'hF, 32'h0,         32'h0000_02F1};
    vecs[15] = '{2'd1, 1'b1, 4'hF, 32'h0,         32'h0};
    vecs[16] = '{2'd1, 1'b0, 4'hF, 32'h0,         32'h0};
    vecs[17] = '{2'd3, 1'b0, 4'hF, 32'h0,         32'h0};
    vecs[18] = '{2'd0, 1'b1, 4'hF, 32'h0000_1234, 32'h0};
    vecs[19] = '{2'd1, 1'b1, 4'hF, 32'h0000_0001, 32'h0};

    wb.adr_i = '0; wb.dat_i = '0; wb.sel_i = '0;
    wb.we_i = 1'b0; wb.stb_i = 1'b0; wb.cyc_i = 1'b0;

    // Reset state and first digit after release
    repeat (3) @(negedge clock);
    check("rst ack_o", 32'(wb.ack_o), 32'd0);
    check("rst dat_o", wb.dat_o, 32'd0);
    check("rst an_n",  32'(an_n),  32'hF);
    check("rst seg_n", 32'(seg_n), 32'h7F);
    check("rst dp_n",  32'(dp_n),  32'd1);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);
    check("first an_n",  32'(an_n),  32'hE);
    check("first seg_n", 32'(seg_n), 32'h40);

    for (int i = 0; i < 20; i++)
      wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].dat, vecs[i].exp, $sformatf("vec%0d", i));

    // Digit sequence for 0x1234, each slot held SCAN_DIV cycles
    wait_an(4'h7, "scan d3");
    wait_an(4'hE, "scan d0");
    for (int k = 0; k < 4; k++) begin
      check($sformatf("scan seg d%0d", k), 32'(seg_n), 32'(seq[k]));
      cnt = 0;
      do begin
        @(negedge clock);
        cnt++;
      end while (an_n == ~(4'b0001 << k) && cnt < 10);
      check($sformatf("scan hold d%0d", k), 32'(cnt), SCAN_DIV);
    end

    // Byte-lane write shows 'b' on digit 2
    wb_xfer(2'd0, 1'b1, 4'h2, 32'h0000_AB00, 32'h0, "lane wr");
    wb_xfer(2'd0, 1'b0, 4'hF, 32'h0, 32'h0000_AB34, "lane rd");
    wait_an(4'hB, "lane d2");
    check("lane seg d2", 32'(seg_n), 32'h03);

    // dp on digit 0, digit 1 blanked
    wb_xfer(2'd1, 1'b1, 4'hF, 32'h0000_0211, 32'h0, "ctrl211");
    wait_an(4'h7, "ctrl211 d3");
    wait_an(4'hE, "ctrl211 d0");
    check("ctrl211 dp d0", 32'(dp_n), 32'd0);
    repeat (SCAN_DIV) @(negedge clock);
    check("ctrl211 an d1",  32'(an_n),  32'hF);
    check("ctrl211 seg d1", 32'(seg_n), 32'h7F);

    // Disable: dark throughout, then resume where the scan is
    wb_xfer(2'd1, 1'b1, 4'hF, 32'h0, 32'h0, "ctrl0");
    for (int i = 0; i < 8; i++) begin
      check("ctrl0 dark", 32'(an_n), 32'hF);
      @(negedge clock);
    end
    wb_xfer(2'd1, 1'b1, 4'hF, 32'h0000_0001, 32'h0, "ctrl1");
    repeat (8) @(negedge clock);

    // Strobe held for 6 cycles
    @(negedge clock);
    wb.adr_i = 32'h0; wb.we_i = 1'b0; wb.sel_i = 4'hF;
    wb.cyc_i = 1'b1;  wb.stb_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (wb.ack_o) begin
        acks++;
        check("held rdata", wb.dat_o, 32'h0000_AB34);
      end
    end
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0;
    check("held acks", 32'(acks), 32'd3);
    $display("held strobe acks=%0d", acks);

    // Strobe withdrawn before any clock edge samples it
    @(negedge clock);
    wb.adr_i = 32'h0; wb.we_i = 1'b1; wb.sel_i = 4'hF; wb.dat_i = 32'h0000_DEAD;
    wb.cyc_i = 1'b1;  wb.stb_i = 1'b1;
    #2;
    wb.cyc_i = 1'b0;  wb.stb_i = 1'b0; wb.we_i = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clock);
      if (wb.ack_o) acks++;
    end
    check("abort acks", 32'(acks), 32'd0);
    $display("aborted access acks=%0d", acks);
    wb_xfer(2'd0, 1'b0, 4'hF, 32'h0, 32'h0000_AB34, "abort rd");

    // Reset asserted while a write is being acknowledged
    @(negedge clock);
    wb.adr_i = 32'h0; wb.we_i = 1'b1; wb.sel_i = 4'hF; wb.dat_i = 32'h0000_5555;
    wb.cyc_i = 1'b1;  wb.stb_i = 1'b1;
    @(posedge clock);
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("midrst ack_o", 32'(wb.ack_o), 32'd0);
    check("midrst dat_o", wb.dat_o, 32'd0);
    check("midrst an_n",  32'(an_n),  32'hF);
    check("midrst seg_n", 32'(seg_n), 32'h7F);
    check("midrst dp_n",  32'(dp_n),  32'd1);
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
    @(negedge clock);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);
    check("midrst first an",  32'(an_n),  32'hE);
    check("midrst first seg", 32'(seg_n), 32'h40);
    wb_xfer(2'd0, 1'b0, 4'hF, 32'h0, 32'h0, "midrst data");
    wb_xfer(2'd1, 1'b0, 4'hF, 32'h0, 32'h0000_0001, "midrst ctrl");

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
